axis_sync_fifo: RTL and testbench

AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

---
 rtl/axis_sync_fifo.sv | 109 ++++++++++
 tb/tb_axis_sync_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO, first-word-fall-through with a registered output beat.
// Optional packet mode releases beats only once a complete packet (or a full FIFO) is held.
module axis_sync_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ADDR_WIDTH      = $clog2(DEPTH),
  parameter int unsigned PACKET_MODE     = 0,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_TH = PW'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr_nx;
  logic [ADDR_WIDTH:0]   rd_ptr_nx;
  logic [ADDR_WIDTH:0]   level_nx;
  logic [ADDR_WIDTH:0]   pkt_nx;
  logic                  push_c;
  logic                  pop_c;
  logic                  full_nx;
  logic                  valid_nx;
  logic                  load_c;
  logic [DATA_WIDTH:0]   head_nx;

  // Next-state of pointers, occupancy, packet count and the output beat
  always_comb begin
    push_c    = s_axis_tvalid && s_axis_tready;
    pop_c     = m_axis_tvalid && m_axis_tready;
    wr_ptr_nx = wr_ptr + PW'(push_c);
    rd_ptr_nx = rd_ptr + PW'(pop_c);
    level_nx  = wr_ptr_nx - rd_ptr_nx;
    full_nx   = (wr_ptr_nx[ADDR_WIDTH] != rd_ptr_nx[ADDR_WIDTH]) &&
                (wr_ptr_nx[ADDR_WIDTH-1:0] == rd_ptr_nx[ADDR_WIDTH-1:0]);

    pkt_nx = pkt_count;
    if (push_c && s_axis_tlast && !(pop_c && m_axis_tlast)) begin
      pkt_nx = pkt_count + PW'(1);
    end else if (pop_c && m_axis_tlast && !(push_c && s_axis_tlast)) begin
      pkt_nx = pkt_count - PW'(1);
    end

    // Packet mode: a presented beat stays valid until taken, full FIFO escapes deadlock
    if (PACKET_MODE != 0) begin
      valid_nx = ((level_nx != '0) && ((pkt_nx != '0) || full_nx)) ||
                 (m_axis_tvalid && !pop_c);
    end else begin
      valid_nx = (level_nx != '0);
    end

    // Output register mirrors the head entry; bypass when the head is being written now
    load_c  = (level_nx != '0) && (pop_c || (level == '0));
    head_nx = (rd_ptr_nx == wr_ptr) ? {s_axis_tlast, s_axis_tdata}
                                    : mem[rd_ptr_nx[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      pkt_count     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      s_axis_tready <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nx;
      rd_ptr        <= rd_ptr_nx;
      level         <= level_nx;
      pkt_count     <= pkt_nx;
      m_axis_tvalid <= valid_nx;
      almost_full   <= (level_nx >= AF_TH);
      almost_empty  <= (level_nx <= AE_TH);
      s_axis_tready <= !full_nx;
      if (load_c) begin
        {m_axis_tlast, m_axis_tdata} <= head_nx;
      end
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Drives a streaming FIFO in normal and packet mode side by side and checks every
// cycle against queue-based reference models.
module tb_axis_sync_fifo;

  typedef logic [32:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b0;

  logic        rdy0, v0, l0, af0, ae0;
  logic [31:0] d0;
  logic [4:0]  lvl0, pk0;
  logic        rdy1, v1, l1, af1, ae1;
  logic [31:0] d1;
  logic [4:0]  lvl1, pk1;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t q0[$];
  beat_t q1[$];
  bit    rst_last = 1'b1;
  bit    ev1 = 1'b0;

  always #5 clk = ~clk;

  axis_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy0),
    .m_axis_tdata(d0), .m_axis_tlast(l0), .m_axis_tvalid(v0), .m_axis_tready(m_tready),
    .level(lvl0), .almost_full(af0), .almost_empty(ae0), .pkt_count(pk0)
  );

  axis_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy1),
    .m_axis_tdata(d1), .m_axis_tlast(l1), .m_axis_tvalid(v1), .m_axis_tready(m_tready),
    .level(lvl1), .almost_full(af1), .almost_empty(ae1), .pkt_count(pk1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_last(input beat_t q[$]);
    int c = 0;
    foreach (q[i]) if (q[i][32]) c++;
    return c;
  endfunction

  task automatic chk_dut(input string nm, input bit exp_v, input beat_t q[$],
                         input logic o_rdy, input logic o_v, input logic [31:0] o_d,
                         input logic o_l, input logic [4:0] o_lvl, input logic [4:0] o_pk,
                         input logic o_af, input logic o_ae);
    int n = q.size();
    chk({nm, ".tready"}, 64'(o_rdy), 64'(!rst_last && n < 16));
    chk({nm, ".tvalid"}, 64'(o_v), 64'(exp_v));
    chk({nm, ".level"}, 64'(o_lvl), 64'(n));
    chk({nm, ".pkt_count"}, 64'(o_pk), 64'(count_last(q)));
    chk({nm, ".almost_full"}, 64'(o_af), 64'(n >= 14));
    chk({nm, ".almost_empty"}, 64'(o_ae), 64'(n <= 2));
    if (exp_v) begin
      chk({nm, ".tdata"}, 64'(o_d), 64'(q[0][31:0]));
      chk({nm, ".tlast"}, 64'(o_l), 64'(q[0][32]));
    end
    if (rst_last) begin
      chk({nm, ".rst_tdata"}, 64'(o_d), 64'(0));
      chk({nm, ".rst_tlast"}, 64'(o_l), 64'(0));
    end
  endtask

  // One clock: predict transfers from model state, advance models, then compare
  task automatic tick();
    bit push0, pop0, push1, pop1;
    int n1;
    push0 = s_tvalid && !rst_last && (q0.size() < 16);
    pop0  = m_tready && (q0.size() > 0);
    push1 = s_tvalid && !rst_last && (q1.size() < 16);
    pop1  = m_tready && ev1;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (pop0) void'(q0.pop_front());
      if (push0) q0.push_back({s_tlast, s_tdata});
      if (pop1) void'(q1.pop_front());
      if (push1) q1.push_back({s_tlast, s_tdata});
    end
    n1  = q1.size();
    ev1 = (n1 > 0) && (count_last(q1) > 0 || n1 == 16);
    #1;
    chk_dut("pm0", q0.size() > 0, q0, rdy0, v0, d0, l0, lvl0, pk0, af0, ae0);
    chk_dut("pm1", ev1, q1, rdy1, v1, d1, l1, lvl1, pk1, af1, ae1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int wp, rp;

    // Reset state and first cycle after reset
    do_reset(2);

    // Fill with 17 beats and no reads; 17th must be refused
    m_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_tvalid = 1'b1;
      s_tlast  = 1'b0;
      s_tdata  = 32'(i);
      tick();
    end
    s_tvalid = 1'b0;
    tick();

    // Drain; packet-mode instance releases one beat then gates again
    m_tready = 1'b1;
    repeat (18) tick();

    // Hold level at 5 with simultaneous write and read for 40 cycles
    do_reset(1);
    m_tready = 1'b0;
    s_tlast  = 1'b1;
    for (int i = 0; i < 45; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h100 + 32'(i);
      if (i == 5) m_tready = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    repeat (6) tick();

    // Three-beat packet; packet mode must wait for the tlast beat
    do_reset(1);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tlast  = (i == 2);
      s_tdata  = 32'hC0 + 32'(i);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (5) tick();

    // Randomized traffic in four load profiles, with one mid-stream reset
    do_reset(1);
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 80; end
        2: begin wp = 60; rp = 60; end
        default: begin wp = 95; rp = 95; end
      endcase
      for (int c = 0; c < 200; c++) begin
        s_tvalid = ($urandom_range(0, 99) < wp);
        m_tready = ($urandom_range(0, 99) < rp);
        s_tlast  = ($urandom_range(0, 3) == 0);
        s_tdata  = $urandom;
        rst      = (ph == 2 && c == 100);
        tick();
      end
    end
    rst = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (20) tick();

    // Held beat, then reset with a beat offered during reset
    do_reset(1);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    s_tdata  = 32'hA5A5A5A5;
    tick();
    s_tvalid = 1'b0;
    repeat (3) tick();
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h12345678;
    tick();
    rst = 1'b0;
    tick();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
